// File: rtl/gemm_pkg.sv
// Shared types and default widths for the GeMM run tracker.
package gemm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int CNT_W_DEF = 32;
  localparam int MAT_W_DEF = 5;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // NOTE: count_d gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/gemm_run_tracker.sv
// Tracks one GeMM run: URAM load, compute, per-matrix completion and the PS done handshake.
module gemm_run_tracker
  import gemm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int MAT_W = MAT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             soft_reset_i,
  input  logic [63:0]      row_uram_wea_i,
  input  logic [63:0]      col_uram_wea_i,
  input  logic             compute_start_i,
  input  logic             mat_done_i,
  input  logic [MAT_W-1:0] num_mat_cfg_i,
  input  logic             ps_app_done_i,
  output logic             dut_done_o,
  output logic [MAT_W-1:0] num_mat_done_o,
  output logic [CNT_W-1:0] active_clk_count_o,
  output logic             busy_o,
  output logic             err_o
);

  state_e           state_q;
  logic [MAT_W-1:0] cfg_q;
  logic             dut_done_q;
  logic             busy_q;
  logic             err_q;
  logic [MAT_W-1:0] num_mat_q;

  logic any_wea;
  logic load_start;
  logic run_en;
  logic mat_en;
  logic last_mat;
  logic cnt_clr;

  assign any_wea    = (|row_uram_wea_i) | (|col_uram_wea_i);
  // A PS ack still held high in IDLE blocks a new load until it drops.
  assign load_start = (state_q == IDLE) && any_wea && !ps_app_done_i;
  assign run_en     = (state_q == RUN);
  assign mat_en     = run_en && mat_done_i;
  assign last_mat   = mat_en && ((num_mat_q + MAT_W'(1)) == cfg_q);
  assign cnt_clr    = soft_reset_i || load_start;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .clr_i   (cnt_clr),
    .en_i    (run_en),
    .count_o (active_clk_count_o)
  );

  sat_counter #(.W(MAT_W)) u_mat_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .clr_i   (cnt_clr),
    .en_i    (mat_en),
    .count_o (num_mat_q)
  );

  always_ff @(posedge clk) begin
    if (!resetn || soft_reset_i) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      dut_done_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if ((mat_done_i && state_q != RUN) || (compute_start_i && state_q != LOAD)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
            cfg_q   <= '0;
          end
        end
        LOAD: begin
          // Start wins over any write enables still active this cycle.
          if (compute_start_i) begin
            cfg_q <= num_mat_cfg_i;
            if (num_mat_cfg_i == '0) begin
              state_q    <= DONE;
              busy_q     <= 1'b0;
              dut_done_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (last_mat) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            dut_done_q <= 1'b1;
          end
        end
        DONE: begin
          if (ps_app_done_i) begin
            state_q    <= IDLE;
            dut_done_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          dut_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign dut_done_o     = dut_done_q;
  assign num_mat_done_o = num_mat_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_gemm_run_tracker.sv
// Scoreboard bench: expected run results are queued at compute start and checked when dut_done rises.
module tb_gemm_run_tracker;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        soft_reset = 1'b0;
  logic [63:0] row_wea = '0;
  logic [63:0] col_wea = '0;
  logic        start = 1'b0;
  logic        mat_done = 1'b0;
  logic [4:0]  cfg = '0;
  logic        ps_done = 1'b0;

  logic        done_m, busy_m, err_m;
  logic [4:0]  nmat_m;
  logic [31:0] cnt_m;
  logic        done_s, busy_s, err_s;
  logic [4:0]  nmat_s;
  logic [3:0]  cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0]  mats;
    logic [31:0] cnt;
  } exp_t;

  exp_t q_main[$];
  exp_t q_sat[$];

  always #5 clk = ~clk;

  gemm_run_tracker #(.CNT_W(32), .MAT_W(5)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .soft_reset_i       (soft_reset),
    .row_uram_wea_i     (row_wea),
    .col_uram_wea_i     (col_wea),
    .compute_start_i    (start),
    .mat_done_i         (mat_done),
    .num_mat_cfg_i      (cfg),
    .ps_app_done_i      (ps_done),
    .dut_done_o         (done_m),
    .num_mat_done_o     (nmat_m),
    .active_clk_count_o (cnt_m),
    .busy_o             (busy_m),
    .err_o              (err_m)
  );

  gemm_run_tracker #(.CNT_W(4), .MAT_W(5)) dut_sat (
    .clk                (clk),
    .resetn             (resetn),
    .soft_reset_i       (soft_reset),
    .row_uram_wea_i     (row_wea),
    .col_uram_wea_i     (col_wea),
    .compute_start_i    (start),
    .mat_done_i         (mat_done),
    .num_mat_cfg_i      (cfg),
    .ps_app_done_i      (ps_done),
    .dut_done_o         (done_s),
    .num_mat_done_o     (nmat_s),
    .active_clk_count_o (cnt_s),
    .busy_o             (busy_s),
    .err_o              (err_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected end-of-run result; the 4-bit instance saturates at 15.
  task automatic push_exp(input int mats, input int cycles);
    exp_t e;
    e.mats = 5'(mats);
    e.cnt  = 32'(cycles);
    q_main.push_back(e);
    e.cnt  = (cycles > 15) ? 32'd15 : 32'(cycles);
    q_sat.push_back(e);
  endtask

  task automatic run_mats(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap - 1) tick();
      mat_done = 1'b1;
      tick();
      mat_done = 1'b0;
    end
  endtask

  task automatic ack();
    ps_done = 1'b1;
    tick();
    ps_done = 1'b0;
    tick();
  endtask

  // Monitors: compare against the scoreboard on every rising dut_done.
  logic prev_m = 1'b0;
  logic prev_s = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (done_m && !prev_m) begin
      if (q_main.size() == 0) begin
        check("main_unexpected_done", 64'd1, 64'd0);
      end else begin
        e = q_main.pop_front();
        check("main_num_mat", 64'(nmat_m), 64'(e.mats));
        check("main_count", 64'(cnt_m), 64'(e.cnt));
      end
    end
    if (done_s && !prev_s) begin
      if (q_sat.size() == 0) begin
        check("sat_unexpected_done", 64'd1, 64'd0);
      end else begin
        e = q_sat.pop_front();
        check("sat_num_mat", 64'(nmat_s), 64'(e.mats));
        check("sat_count", 64'(cnt_s), 64'(e.cnt));
      end
    end
    prev_m = done_m;
    prev_s = done_s;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_done", 64'(done_m), 64'd0);
    check("rst_nmat", 64'(nmat_m), 64'd0);
    check("rst_cnt", 64'(cnt_m), 64'd0);
    check("rst_busy", 64'(busy_m), 64'd0);
    check("rst_err", 64'(err_m), 64'd0);
    resetn = 1'b1;
    tick();

    // 1: normal run, cfg=4, mat_done every 10 cycles
    row_wea = 64'h1;
    tick();
    row_wea = '0;
    check("t1_busy_load", 64'(busy_m), 64'd1);
    cfg = 5'd4;
    start = 1'b1;
    push_exp(4, 40);
    tick();
    start = 1'b0;
    run_mats(3, 10);
    repeat (9) tick();
    check("t1_done_early", 64'(done_m), 64'd0);
    mat_done = 1'b1;
    tick();
    mat_done = 1'b0;
    check("t1_done", 64'(done_m), 64'd1);
    check("t1_nmat", 64'(nmat_m), 64'd4);
    check("t1_cnt", 64'(cnt_m), 64'd40);
    check("t1_busy_done", 64'(busy_m), 64'd0);
    check("t1_err", 64'(err_m), 64'd0);

    // 2: handshake, held ack blocks a new load
    ps_done = 1'b1;
    tick();
    check("t2_done_clr", 64'(done_m), 64'd0);
    for (int i = 0; i < 5; i++) begin
      row_wea = (i % 2 == 1) ? '1 : '0;
      tick();
      check("t2_no_load", 64'(busy_m), 64'd0);
    end
    check("t2_keep_nmat", 64'(nmat_m), 64'd4);
    check("t2_keep_cnt", 64'(cnt_m), 64'd40);
    row_wea = '0;
    ps_done = 1'b0;
    tick();
    col_wea = 64'h8000_0000_0000_0000;
    tick();
    col_wea = '0;
    check("t2_load_busy", 64'(busy_m), 64'd1);
    check("t2_load_nmat", 64'(nmat_m), 64'd0);
    check("t2_load_cnt", 64'(cnt_m), 64'd0);

    // 3: cfg=0 goes straight to DONE; start wins over concurrent wea
    cfg = 5'd0;
    start = 1'b1;
    col_wea = '1;
    push_exp(0, 0);
    tick();
    start = 1'b0;
    col_wea = '0;
    check("t3_done", 64'(done_m), 64'd1);
    check("t3_busy", 64'(busy_m), 64'd0);
    check("t3_cnt", 64'(cnt_m), 64'd0);
    ack();

    // 4: protocol errors are sticky and do not disturb counters
    mat_done = 1'b1;
    tick();
    mat_done = 1'b0;
    check("t4_err_idle", 64'(err_m), 64'd1);
    check("t4_nmat_idle", 64'(nmat_m), 64'd0);
    row_wea = 64'h10;
    tick();
    row_wea = '0;
    cfg = 5'd2;
    start = 1'b1;
    push_exp(2, 25);
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_err_run", 64'(err_m), 64'd1);
    check("t4_busy_run", 64'(busy_m), 64'd1);
    check("t4_cnt_run", 64'(cnt_m), 64'd5);
    check("t4_nmat_run", 64'(nmat_m), 64'd0);
    run_mats(2, 10);
    check("t4_done", 64'(done_m), 64'd1);
    ack();
    check("t4_err_sticky", 64'(err_m), 64'd1);

    // 5: soft reset aborts a run
    row_wea = 64'h2;
    tick();
    row_wea = '0;
    cfg = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("t5_cnt7", 64'(cnt_m), 64'd7);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check("t5_done", 64'(done_m), 64'd0);
    check("t5_nmat", 64'(nmat_m), 64'd0);
    check("t5_cnt", 64'(cnt_m), 64'd0);
    check("t5_busy", 64'(busy_m), 64'd0);
    check("t5_err", 64'(err_m), 64'd0);
    check("t5_sat_cnt", 64'(cnt_s), 64'd0);
    tick();
    check("t5_idle", 64'(busy_m), 64'd0);

    // 6: 4-bit counter saturates at 15 over a 20-cycle run
    col_wea = 64'h4;
    tick();
    col_wea = '0;
    cfg = 5'd1;
    start = 1'b1;
    push_exp(1, 20);
    tick();
    start = 1'b0;
    repeat (16) tick();
    check("t6_sat_hold", 64'(cnt_s), 64'd15);
    check("t6_main_16", 64'(cnt_m), 64'd16);
    repeat (3) tick();
    mat_done = 1'b1;
    tick();
    mat_done = 1'b0;
    check("t6_sat_final", 64'(cnt_s), 64'd15);
    check("t6_main_final", 64'(cnt_m), 64'd20);
    ack();

    repeat (3) tick();
    check("sb_main_drained", 64'(q_main.size()), 64'd0);
    check("sb_sat_drained", 64'(q_sat.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
